elastic_fifo_param: RTL and testbench

Parametrised multi-entry elastic buffer for srdy/rrdy (valid/ready) streams. It is the generalised successor to the single-entry elastic stage, with configurable data width, depth and almost-full threshold. It sustains one transfer per cycle, including simultaneous push and pop when full. It sits between pipeline stages or clock-aligned producer/consumer pairs that need more than one entry of slack, with an optional same-cycle bypass when empty.

---
 rtl/elastic_fifo_param.sv | 123 ++++++++++++
 tb/tb_elastic_fifo_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_fifo_param.sv
// -----------------------------------------------------------------------------
// elastic_fifo_param
//
// Parametrised multi-entry elastic buffer for srdy/rrdy (valid/ready) streams.
// A circular register array with read/write pointers. It sustains one transfer
// per cycle at any fill level, including a simultaneous push and pop when full.
//
// Parameters:
//   WIDTH     - data width in bits (>= 1)
//   DEPTH     - number of entries, power of two, >= 2
//   AF_THRESH - almost_full asserts when count >= AF_THRESH (1..DEPTH)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_srdy      upstream data valid
//   in_data      upstream data
//   in_rrdy      block accepts in_data this cycle (combinational from out_rrdy)
//   out_rrdy     downstream accepts out_data this cycle
//   out_srdy     out_data valid
//   out_data     head-of-queue data
//   count        number of stored entries
//   almost_full  registered, count >= AF_THRESH
//
// Optional feature (macro ELASTIC_FIFO_BYPASS_EN):
//   When the macro is defined, an empty FIFO with in_srdy & out_rrdy passes
//   in_data straight to out_data in the same cycle without storing it.
//   When it is undefined, there is no in_data -> out_data combinational path.
// -----------------------------------------------------------------------------
module elastic_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_srdy,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_rrdy,
  input  logic                       out_rrdy,
  output logic                       out_srdy,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             almost_full_q;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign in_rrdy = ~full | out_rrdy;

`ifdef ELASTIC_FIFO_BYPASS_EN
  logic bypass;

  // Empty and both sides ready: the word flows through without being stored.
  assign bypass   = empty & in_srdy & out_rrdy;
  assign out_srdy = ~empty | bypass;
  assign out_data = bypass ? in_data : mem_q[rd_ptr_q];
  assign push     = in_srdy & in_rrdy & ~bypass;
  assign pop      = ~empty & out_rrdy;
`else
  assign out_srdy = ~empty;
  assign out_data = mem_q[rd_ptr_q];
  assign push     = in_srdy & in_rrdy;
  assign pop      = out_srdy & out_rrdy;
`endif

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array is cleared on reset because out_data reads
  // mem_q[rd_ptr_q] directly and must show zero after reset; this costs a
  // reset on every storage flop instead of letting the array power up unknown.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        // Power-of-two depth: the pointer wraps DEPTH-1 -> 0 by overflow.
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q       <= count_d;
      // Registered from the next count so it lines up with count.
      almost_full_q <= (count_d >= CW'(AF_THRESH));
    end
  end

  assign count       = count_q;
  assign almost_full = almost_full_q;

endmodule

// File: tb/tb_elastic_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_elastic_fifo_param
//
// Self-checking bench for elastic_fifo_param (WIDTH=8, DEPTH=4, AF_THRESH=3).
// Inputs are driven on the falling edge; outputs are sampled 1 ns later, so
// each sample shows the registered state plus the combinational response to
// the inputs about to be committed by the next rising edge.
// Build with ELASTIC_FIFO_BYPASS_EN defined to exercise the bypass variant.
// -----------------------------------------------------------------------------
module tb_elastic_fifo_param;

  logic       clk;
  logic       reset;
  logic       in_srdy;
  logic [7:0] in_data;
  logic       in_rrdy;
  logic       out_rrdy;
  logic       out_srdy;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       almost_full;

  int n_vec;
  int n_err;

  elastic_fifo_param #(
    .WIDTH    (8),
    .DEPTH    (4),
    .AF_THRESH(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_srdy    (in_srdy),
    .in_data    (in_data),
    .in_rrdy    (in_rrdy),
    .out_rrdy   (out_rrdy),
    .out_srdy   (out_srdy),
    .out_data   (out_data),
    .count      (count),
    .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One row: inputs held for one cycle, outputs expected before the edge.
  typedef struct {
    logic       in_srdy;
    logic [7:0] in_data;
    logic       out_rrdy;
    logic       e_in_rrdy;
    logic       e_out_srdy;
    logic [7:0] e_out_data;
    logic [2:0] e_count;
    logic       e_af;
  } vec_t;

  vec_t vecs [10];

  logic [7:0] next_in;
  logic [7:0] next_out;
  logic       hold;
  logic [7:0] hold_data;
  logic       drained;

  initial begin
    n_vec = 0;
    n_err = 0;

    // Fill with out_rrdy=0, offer a fifth word, then drain in order.
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b1};
    vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 3'd4, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd1, 1'b0};
    // Empty again: rd_ptr has wrapped to slot 0, which still holds 0x11.
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 3'd0, 1'b0};

    reset    = 1'b1;
    in_srdy  = 1'b1;
    in_data  = 8'hEE;
    out_rrdy = 1'b1;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    in_srdy  = 1'b0;
    out_rrdy = 1'b0;
    #1;
    check("reset count",    count,       0);
    check("reset out_srdy", out_srdy,    0);
    check("reset out_data", out_data,    0);
    check("reset in_rrdy",  in_rrdy,     1);
    check("reset af",       almost_full, 0);

    // ---- table: fill, overflow refusal, drain ----
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_srdy  = vecs[i].in_srdy;
      in_data  = vecs[i].in_data;
      out_rrdy = vecs[i].out_rrdy;
      #1;
      check($sformatf("v%0d in_rrdy", i),  in_rrdy,     vecs[i].e_in_rrdy);
      check($sformatf("v%0d out_srdy", i), out_srdy,    vecs[i].e_out_srdy);
      check($sformatf("v%0d out_data", i), out_data,    vecs[i].e_out_data);
      check($sformatf("v%0d count", i),    count,       vecs[i].e_count);
      check($sformatf("v%0d af", i),       almost_full, vecs[i].e_af);
    end

    // ---- full streaming: push and pop together at count=4 ----
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_srdy  = 1'b1;
      in_data  = 8'h80 + 8'(i);
      out_rrdy = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_srdy  = 1'b1;
      in_data  = 8'h84 + 8'(i);
      out_rrdy = 1'b1;
      #1;
      check($sformatf("stream%0d count", i),    count,    4);
      check($sformatf("stream%0d in_rrdy", i),  in_rrdy,  1);
      check($sformatf("stream%0d out_data", i), out_data, 8'h80 + 8'(i));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_srdy  = 1'b0;
      out_rrdy = 1'b1;
      #1;
      check($sformatf("stream drain%0d", i), out_data, 8'h8A + 8'(i));
    end
    @(negedge clk);
    out_rrdy = 1'b0;
    #1;
    check("stream end count",    count,    0);
    check("stream end out_srdy", out_srdy, 0);

    // ---- random backpressure with an incrementing source ----
    next_in  = 8'h00;
    next_out = 8'h00;
    hold     = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      in_srdy  = 1'b1;
      in_data  = next_in;
      out_rrdy = 1'($urandom_range(0, 1));
      #1;
      if (hold) begin
        check("bp hold srdy", out_srdy, 1);
        check("bp hold data", out_data, hold_data);
      end
      if (out_srdy && out_rrdy) begin
        check("bp order", out_data, next_out);
        next_out++;
      end
      hold      = out_srdy & ~out_rrdy;
      hold_data = out_data;
      if (in_rrdy) next_in++;
    end
    drained = 1'b0;
    for (int c = 0; c < 10 && !drained; c++) begin
      @(negedge clk);
      in_srdy  = 1'b0;
      out_rrdy = 1'b1;
      #1;
      if (!out_srdy) begin
        drained = 1'b1;
      end else begin
        check("bp drain order", out_data, next_out);
        next_out++;
      end
    end
    check("bp drained",        drained,  1);
    check("bp all delivered",  next_out, next_in);
    check("bp end count",      count,    0);

    // ---- reset mid-operation at count=2 ----
    @(negedge clk);
    in_srdy  = 1'b1;
    in_data  = 8'h31;
    out_rrdy = 1'b0;
    @(negedge clk);
    in_data  = 8'h32;
    @(negedge clk);
    in_srdy  = 1'b0;
    #1;
    check("mid pre-reset count", count, 2);
    reset    = 1'b1;
    in_srdy  = 1'b1;
    in_data  = 8'h77;
    out_rrdy = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_srdy  = 1'b0;
    out_rrdy = 1'b0;
    #1;
    check("mid reset count",    count,       0);
    check("mid reset out_srdy", out_srdy,    0);
    check("mid reset out_data", out_data,    0);
    check("mid reset in_rrdy",  in_rrdy,     1);
    check("mid reset af",       almost_full, 0);
    in_srdy = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    in_srdy = 1'b0;
    #1;
    check("post reset out_srdy", out_srdy, 1);
    check("post reset out_data", out_data, 8'hA5);
    check("post reset count",    count,    1);
    out_rrdy = 1'b1;
    @(negedge clk);
    out_rrdy = 1'b0;
    #1;
    check("post reset drained", count, 0);

    // ---- empty FIFO, both sides ready ----
    @(negedge clk);
    in_srdy  = 1'b1;
    in_data  = 8'h5A;
    out_rrdy = 1'b1;
    #1;
`ifdef ELASTIC_FIFO_BYPASS_EN
    check("bypass out_srdy", out_srdy, 1);
    check("bypass out_data", out_data, 8'h5A);
    @(negedge clk);
    in_srdy  = 1'b0;
    out_rrdy = 1'b0;
    #1;
    check("bypass count",     count,    0);
    check("bypass after srdy", out_srdy, 0);
`else
    check("no-bypass same-cycle srdy", out_srdy, 0);
    @(negedge clk);
    in_srdy  = 1'b0;
    out_rrdy = 1'b1;
    #1;
    check("no-bypass out_srdy", out_srdy, 1);
    check("no-bypass out_data", out_data, 8'h5A);
    check("no-bypass count",    count,    1);
    @(negedge clk);
    out_rrdy = 1'b0;
    #1;
    check("no-bypass drained", count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
